vga_scanout: RTL
================

VGA_SCANOUT -- requirements
Module: vga_scanout

Interface
REQ-001 SHALL have parameter H_ACTIVE, 640, visible pixels per line.
REQ-002 SHALL have parameter H_FP, 16, horizontal front porch clocks.
REQ-003 SHALL have parameter H_SYNC, 96, hsync pulse clocks.
REQ-004 SHALL have parameter H_BP, 48, horizontal back porch clocks.
REQ-005 SHALL have parameter V_ACTIVE, 480, visible lines per frame.
REQ-006 SHALL have parameter V_FP, 10, vertical front porch lines.
REQ-007 SHALL have parameter V_SYNC, 2, vsync pulse lines.
REQ-008 SHALL have parameter V_BP, 33, vertical back porch lines.
REQ-009 SHALL have parameter X_OFFSET, 192, first visible column of the 256x256 image window.
REQ-010 SHALL have parameter Y_OFFSET, 112, first visible line of the image window.
REQ-011 SHALL have port clock  in  1  pixel clock (25.175 MHz nominal); the only clock.
REQ-012 SHALL have port reset_n  in  1  asynchronous, active-low reset.
REQ-013 SHALL have port border_color  in  8  RGB332 colour for active pixels outside the image window.
REQ-014 SHALL have port fb_rdata  in  8  RGB332 pixel from framebuffer read port, valid one clock after fb_read_addr.
REQ-015 SHALL have port fb_read_addr  out  16  framebuffer read address, {row[7:0], col[7:0]}.
REQ-016 SHALL have ports vga_r, vga_g, vga_b  out  8 each  pixel colour.
REQ-017 SHALL have ports vga_hsync, vga_vsync  out  1 each  active-low syncs.
REQ-018 SHALL have port vga_blank_n  out  1  high during visible pixels.
REQ-019 SHALL have port vblank  out  1  high while v_cnt >= V_ACTIVE (safe window for framebuffer writers), unaligned to pipeline.

Function
REQ-020 SHALL keep h_cnt 0..H_TOTAL-1 (H_TOTAL = sum of H_*, 800 default), incrementing every clock, wrapping to 0.
REQ-021 SHALL keep v_cnt 0..V_TOTAL-1 (525 default), incrementing when h_cnt wraps, wrapping to 0 when both wrap together.
REQ-022 SHALL define visible = h_cnt < H_ACTIVE and v_cnt < V_ACTIVE.
REQ-023 SHALL define in_window = visible, X_OFFSET <= h_cnt < X_OFFSET+256, Y_OFFSET <= v_cnt < Y_OFFSET+256.
REQ-024 SHALL register fb_read_addr = {(v_cnt-Y_OFFSET)[7:0], (h_cnt-X_OFFSET)[7:0]} when in_window, else 0 (stage 1).
REQ-025 SHALL treat fb_rdata as valid the clock after fb_read_addr (stage 2, framebuffer registers its read).
REQ-026 SHALL register outputs at stage 3: pixel from counter (h,v) appears on all outputs exactly 3 clocks after counters hold (h,v).
REQ-027 SHALL delay visible, in_window, hsync and vsync through a 3-stage shift so syncs, blank_n and colour stay aligned.
REQ-028 SHALL assert hsync low for H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC (656..751) before delay.
REQ-029 SHALL assert vsync low for V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC (490..491) before delay.
REQ-030 SHALL expand RGB332 p as vga_r={p[7:5],p[7:5],p[7:6]}, vga_g={p[4:2],p[4:2],p[4:3]}, vga_b={p[1:0],p[1:0],p[1:0],p[1:0]}.
REQ-031 SHALL select p = fb_rdata when delayed in_window, border_color (sampled at stage 3) when delayed visible only, and drive RGB 0 when not visible.
REQ-032 SHALL make vga_blank_n equal the delayed visible flag.
REQ-033 SHALL never issue a read address outside 0..65535; subtraction truncates to 8 bits only inside the window.

Reset
REQ-034 SHALL on reset_n low immediately force h_cnt=0, v_cnt=0, fb_read_addr=0, RGB=0, hsync=1, vsync=1, blank_n=0, vblank=0, all delay stages inactive.
REQ-035 SHALL resume counting at (0,0) on the first clock after reset_n deasserts; first visible pixel output 3 clocks later.
REQ-036 SHALL, on reset mid-frame, discard in-flight pipeline data with no partial sync pulse emitted.

Verification
REQ-037 Reset release, count clocks -> blank_n rises on clock 3, hsync period 800 clocks, low for 96; vsync period 420000 clocks, low for 1600.
REQ-038 Framebuffer model with data = addr[7:0]^addr[15:8] -> pixel (192,112) shows data 0x00, (447,367) shows 0x00, (200,120) shows 0x00; (193,112) shows 0x01 expanded.
REQ-039 border_color=0xE0, fb_rdata=0xFF -> pixel (0,0) r=0xFF,g=0,b=0; pixel (300,200) r=g=b=0xFF; h=700 region RGB=0.
REQ-040 Address check -> (h=192,v=112) gives 0x0000, (447,367) gives 0xFFFF, (191,112) and (448,200) give 0x0000.
REQ-041 Assert reset_n low at h=500,v=300 for 2 clocks -> outputs reach reset values asynchronously; counters restart at (0,0).
REQ-042 vblank -> rises at v_cnt=480,h_cnt=0, falls at wrap to v_cnt=0; width 45 lines (36000 clocks).

Source files
------------

// File: rtl/vga_scanout.sv
// ---------------------------------------------------------------------------
// vga_scanout
//   Generates VGA timing from a single pixel clock and scans a 256x256 RGB332
//   image window out of an external framebuffer with a registered read port.
//   Pixels outside the window but inside the visible area use border_color.
//   Pipeline: stage 1 registers the read address and timing flags, stage 2
//   waits for the framebuffer read data, stage 3 registers every video output,
//   so syncs, blank_n and colour for counter position (h,v) appear together
//   three clocks after the counters hold (h,v).
//
// Ports
//   clock         in   1   pixel clock, the only clock
//   reset_n       in   1   asynchronous active-low reset
//   border_color  in   8   RGB332 colour for visible pixels outside the window
//   fb_rdata      in   8   RGB332 framebuffer data, valid one clock after addr
//   fb_read_addr  out 16   framebuffer read address {row[7:0], col[7:0]}
//   vga_r/g/b     out  8   expanded pixel colour (0 outside visible area)
//   vga_hsync     out  1   active-low horizontal sync
//   vga_vsync     out  1   active-low vertical sync
//   vga_blank_n   out  1   high during visible pixels
//   vblank        out  1   high while v_cnt >= V_ACTIVE (not pipeline aligned)
// ---------------------------------------------------------------------------
module vga_scanout #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter int unsigned X_OFFSET = 192,
  parameter int unsigned Y_OFFSET = 112
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [7:0]  border_color,
  input  logic [7:0]  fb_rdata,
  output logic [15:0] fb_read_addr,
  output logic [7:0]  vga_r,
  output logic [7:0]  vga_g,
  output logic [7:0]  vga_b,
  output logic        vga_hsync,
  output logic        vga_vsync,
  output logic        vga_blank_n,
  output logic        vblank
);

  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HW       = $clog2(H_TOTAL);
  localparam int unsigned VW       = $clog2(V_TOTAL);
  localparam int unsigned HS_START = H_ACTIVE + H_FP;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_ACTIVE + V_FP;
  localparam int unsigned VS_END   = VS_START + V_SYNC;
  localparam int unsigned WIN_SIZE = 256;

  // Timing flags carried down the pipeline; hs/vs are "sync asserted" (active high).
  typedef struct packed {
    logic vis;
    logic win;
    logic hs;
    logic vs;
  } stage_t;

  localparam stage_t STAGE_IDLE = '0;

  // RGB332 channel expansion by bit replication.
  function automatic logic [7:0] expand3(input logic [2:0] c);
    return {c, c, c[2:1]};
  endfunction

  function automatic logic [7:0] expand2(input logic [1:0] c);
    return {c, c, c, c};
  endfunction

  logic [HW-1:0] r_h_cnt;
  logic [VW-1:0] r_v_cnt;
  logic [HW-1:0] w_h_next;
  logic [VW-1:0] w_v_next;
  logic          w_h_wrap;
  logic          w_v_wrap;
  logic [31:0]   w_h32;
  logic [31:0]   w_v32;
  stage_t        w_cur;
  logic [15:0]   w_addr;
  logic [7:0]    w_pix;

  stage_t        r_s1;
  stage_t        r_s2;
  logic [15:0]   r_fb_addr;
  logic [7:0]    r_r;
  logic [7:0]    r_g;
  logic [7:0]    r_b;
  logic          r_hsync;
  logic          r_vsync;
  logic          r_blank_n;
  logic          r_vblank;

  // Next counter values: h wraps every line, v advances on h wrap.
  always_comb begin
    w_h_wrap = (32'(r_h_cnt) == H_TOTAL - 1);
    w_v_wrap = (32'(r_v_cnt) == V_TOTAL - 1);
    w_h_next = w_h_wrap ? '0 : r_h_cnt + HW'(1);
    w_v_next = r_v_cnt;
    if (w_h_wrap) begin
      w_v_next = w_v_wrap ? '0 : r_v_cnt + VW'(1);
    end
  end

  // Decode of the current counter position (stage 0).
  always_comb begin
    w_h32     = 32'(r_h_cnt);
    w_v32     = 32'(r_v_cnt);
    w_cur     = STAGE_IDLE;
    w_cur.vis = (w_h32 < H_ACTIVE) && (w_v32 < V_ACTIVE);
    w_cur.win = w_cur.vis &&
                (w_h32 >= X_OFFSET) && (w_h32 < X_OFFSET + WIN_SIZE) &&
                (w_v32 >= Y_OFFSET) && (w_v32 < Y_OFFSET + WIN_SIZE);
    w_cur.hs  = (w_h32 >= HS_START) && (w_h32 < HS_END);
    w_cur.vs  = (w_v32 >= VS_START) && (w_v32 < VS_END);
    // Offsets are only subtracted inside the window, so truncation is safe there.
    w_addr    = w_cur.win ? {8'(w_v32 - Y_OFFSET), 8'(w_h32 - X_OFFSET)} : 16'h0000;
  end

  // Raster counters; vblank tracks the counter itself, not the pipeline.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_h_cnt  <= '0;
      r_v_cnt  <= '0;
      r_vblank <= 1'b0;
    end else begin
      r_h_cnt  <= w_h_next;
      r_v_cnt  <= w_v_next;
      r_vblank <= (32'(w_v_next) >= V_ACTIVE);
    end
  end

  // Stages 1 and 2: address issue and wait for framebuffer read data.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_s1      <= STAGE_IDLE;
      r_s2      <= STAGE_IDLE;
      r_fb_addr <= 16'h0000;
    end else begin
      r_s1      <= w_cur;
      r_s2      <= r_s1;
      r_fb_addr <= w_addr;
    end
  end

  // Colour source for stage 3: framebuffer inside the window, border elsewhere.
  always_comb begin
    w_pix = r_s2.win ? fb_rdata : border_color;
  end

  // Stage 3: every video output registered together.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_r       <= 8'h00;
      r_g       <= 8'h00;
      r_b       <= 8'h00;
      r_hsync   <= 1'b1;
      r_vsync   <= 1'b1;
      r_blank_n <= 1'b0;
    end else begin
      r_hsync   <= ~r_s2.hs;
      r_vsync   <= ~r_s2.vs;
      r_blank_n <= r_s2.vis;
      if (r_s2.vis) begin
        r_r <= expand3(w_pix[7:5]);
        r_g <= expand3(w_pix[4:2]);
        r_b <= expand2(w_pix[1:0]);
      end else begin
        r_r <= 8'h00;
        r_g <= 8'h00;
        r_b <= 8'h00;
      end
    end
  end

  assign fb_read_addr = r_fb_addr;
  assign vga_r        = r_r;
  assign vga_g        = r_g;
  assign vga_b        = r_b;
  assign vga_hsync    = r_hsync;
  assign vga_vsync    = r_vsync;
  assign vga_blank_n  = r_blank_n;
  assign vblank       = r_vblank;

endmodule
